// File: rtl/uart_aes_pkg.sv
// Shared types and constants for the UART-to-AES block assembler.
package uart_aes_pkg;

  localparam int unsigned BLK_W           = 128;
  localparam logic [7:0]  HDR_KEY         = 8'h4B;
  localparam logic [7:0]  HDR_DATA        = 8'h44;
  localparam int unsigned TIMEOUT_CYC_DEF = 3828;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StCollect,
    StHold
  } asm_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte idle counter: cleared on each accepted byte, flags expiry at LIMIT-1.
module uart_timeout_cnt #(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned LIMIT = 3828
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_block_assembler.sv
// Assembles NBYTES UART bytes into one block for the AES core (valid/ready handoff).
// Define UART_ASM_KEYSEL_EN to require a 'K'/'D' header byte ahead of each frame.
module uart_block_assembler
  import uart_aes_pkg::*;
#(
  parameter int unsigned NBYTES      = 16,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = 12
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  rx_byte_pulse,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_error,
  input  logic                  blk_ready,
  input  logic                  err_clr,
  output logic                  blk_valid,
  output logic [8*NBYTES-1:0]   blk_data,
  output logic                  blk_is_key,
  output logic                  busy,
  output logic                  timeout_pulse,
  output logic                  perr_pulse,
  output logic                  overrun,
  output logic [7:0]            err_cnt
);

  localparam int unsigned BW = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LastCnt = CW'(NBYTES - 1);

  asm_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] data_q, data_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    err_q, err_d;
`ifdef UART_ASM_KEYSEL_EN
  logic          key_q, key_d;
`endif

  logic cnt_clr, cnt_inc, cnt_expire;
  logic err_evt, perr_p, tmo_p, start;

  uart_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (sys_clk),
    .rst_ni   (rst_n),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .expire_o (cnt_expire)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    overrun_d = overrun_q;
`ifdef UART_ASM_KEYSEL_EN
    key_d     = key_q;
`endif
    err_evt   = 1'b0;
    perr_p    = 1'b0;
    tmo_p     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_error) begin
          perr_p  = 1'b1;
          err_evt = 1'b1;
        end else if (rx_byte_pulse) begin
          start = 1'b1;
        end
      end
      StHdr: begin
        if (rx_error) begin
          perr_p  = 1'b1;
          err_evt = 1'b1;
          state_d = StIdle;
        end else if (rx_byte_pulse) begin
          data_d  = BW'(rx_byte);
          count_d = CW'(1);
          cnt_clr = 1'b1;
          state_d = StCollect;
        end else if (cnt_expire) begin
          tmo_p   = 1'b1;
          err_evt = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StCollect: begin
        if (rx_error) begin
          perr_p  = 1'b1;
          err_evt = 1'b1;
          count_d = '0;
          state_d = StIdle;
        end else if (rx_byte_pulse) begin
          data_d  = {data_q[BW-9:0], rx_byte};
          count_d = count_q + CW'(1);
          cnt_clr = 1'b1;
          if (count_q == LastCnt) begin
            state_d = StHold;
          end
        end else if (cnt_expire) begin
          tmo_p   = 1'b1;
          err_evt = 1'b1;
          count_d = '0;
          state_d = StIdle;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StHold: begin
        // A byte flagged with a parity error is never taken as the next frame start.
        if (rx_error) begin
          err_evt = 1'b1;
          if (blk_ready) begin
            count_d = '0;
            state_d = StIdle;
          end
        end else if (blk_ready) begin
          count_d = '0;
          state_d = StIdle;
          start   = rx_byte_pulse;
        end else if (rx_byte_pulse) begin
          overrun_d = 1'b1;
          err_evt   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
`ifdef UART_ASM_KEYSEL_EN
      if (rx_byte == HDR_KEY || rx_byte == HDR_DATA) begin
        key_d   = (rx_byte == HDR_KEY);
        count_d = '0;
        cnt_clr = 1'b1;
        state_d = StHdr;
      end else begin
        perr_p  = 1'b1;
        err_evt = 1'b1;
        state_d = StIdle;
      end
`else
      data_d  = BW'(rx_byte);
      count_d = CW'(1);
      cnt_clr = 1'b1;
      state_d = StCollect;
`endif
    end

    err_d = err_evt ? sat_inc8(err_q) : err_q;
    if (err_clr) begin
      err_d     = '0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

`ifdef UART_ASM_KEYSEL_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_d;
    end
  end

  assign blk_is_key = (state_q == StHold) && key_q;
`else
  assign blk_is_key = 1'b0;
`endif

  assign blk_valid     = (state_q == StHold);
  assign blk_data      = data_q;
  assign busy          = (state_q == StCollect) || (state_q == StHdr);
  assign timeout_pulse = tmo_p;
  assign perr_pulse    = perr_p;
  assign overrun       = overrun_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Randomized self-checking bench for uart_block_assembler against a frame-level model.
module tb_uart_block_assembler;

`ifdef UART_ASM_KEYSEL_EN
  localparam bit Feat = 1'b1;
`else
  localparam bit Feat = 1'b0;
`endif

  logic         sys_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_byte_pulse = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         rx_error = 1'b0;
  logic         blk_ready = 1'b0;
  logic         err_clr = 1'b0;
  logic         blk_valid, blk_is_key, busy, timeout_pulse, perr_pulse, overrun;
  logic [127:0] blk_data;
  logic [7:0]   err_cnt;

  uart_block_assembler dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .rx_byte_pulse (rx_byte_pulse),
    .rx_byte       (rx_byte),
    .rx_error      (rx_error),
    .blk_ready     (blk_ready),
    .err_clr       (err_clr),
    .blk_valid     (blk_valid),
    .blk_data      (blk_data),
    .blk_is_key    (blk_is_key),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .perr_pulse    (perr_pulse),
    .overrun       (overrun),
    .err_cnt       (err_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_err = 0;
  int perr_n = 0;
  int tmo_n = 0;
  int tmo_cyc = 0;
  int valid_cyc = 0;
  int last_strobe = 0;
  logic [128:0] got_q[$];
  logic [128:0] exp_q[$];
  logic [7:0]   frame_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (blk_valid && blk_ready) got_q.push_back({blk_is_key, blk_data});
      if (blk_valid) valid_cyc++;
      if (timeout_pulse) begin
        tmo_n++;
        tmo_cyc = cyc;
      end
      if (perr_pulse) perr_n++;
    end
  end

  task automatic check_eq(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [7:0] q[$]);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = q[i];
    return r;
  endfunction

  function automatic logic [7:0] exp_cnt();
    return (exp_err > 255) ? 8'hFF : 8'(exp_err);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_pulse = 1'b1;
    rx_byte       = b;
    last_strobe   = cyc;
    idle(1);
    rx_byte_pulse = 1'b0;
  endtask

  task automatic send_hdr(input logic key);
    if (Feat) begin
      send_byte(key ? 8'h4B : 8'h44);
      idle(1);
    end
  endtask

  // Sends 16 random payload bytes with random gaps; frame_q gets the payload.
  task automatic send_payload(input int gap_max);
    frame_q = {};
    for (int i = 0; i < 16; i++) begin
      frame_q.push_back(8'($urandom));
      send_byte(frame_q[i]);
      idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic check_block(input string tag, input logic key);
    logic [128:0] g;
    check_eq({tag, "_cnt"}, 129'(got_q.size()), 129'(1));
    g = (got_q.size() > 0) ? got_q.pop_front() : '0;
    check_eq(tag, g, {key & Feat, pack(frame_q)});
  endtask

  initial begin
    int t0, p0, v0;
    logic [128:0] held;

    idle(3);
    check_eq("rst_valid", 129'(blk_valid), 129'(0));
    check_eq("rst_busy", 129'(busy), 129'(0));
    check_eq("rst_data", 129'(blk_data), 129'(0));
    check_eq("rst_err", 129'({overrun, err_cnt}), 129'(0));
    rst_n = 1'b1;
    idle(2);

    // Incrementing bytes, 1000 clocks apart, consumer always ready.
    blk_ready = 1'b1;
    v0 = valid_cyc;
    send_hdr(1'b0);
    frame_q = {};
    for (int i = 0; i < 16; i++) begin
      frame_q.push_back(8'(i));
      send_byte(8'(i));
      idle(999);
    end
    check_eq("t1_const", 129'(pack(frame_q)), 129'(128'h000102030405060708090A0B0C0D0E0F));
    check_block("t1_blk", 1'b0);
    check_eq("t1_vcyc", 129'(valid_cyc - v0), 129'(1));
    check_eq("t1_err", 129'(err_cnt), 129'(0));

    // Block held unconsumed, then a 17th byte overruns.
    blk_ready = 1'b0;
    send_hdr(1'b0);
    send_payload(50);
    idle(5000);
    check_eq("t2_valid", 129'(blk_valid), 129'(1));
    held = {1'b0, pack(frame_q)};
    send_byte(8'h5A);
    idle(1);
    exp_err++;
    check_eq("t2_ovr", 129'(overrun), 129'(1));
    check_eq("t2_errc", 129'(err_cnt), 129'(exp_cnt()));
    check_eq("t2_hold", 129'(blk_data), 129'(held[127:0]));
    blk_ready = 1'b1;
    idle(1);
    check_eq("t2_idle", 129'({blk_valid, busy}), 129'(0));
    check_block("t2_blk", 1'b0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    exp_err = 0;
    check_eq("t2_clr", 129'({overrun, err_cnt}), 129'(0));

    // Partial frame then silence: timeout 3828 cycles after the last strobe.
    send_hdr(1'b0);
    for (int i = 0; i < 7; i++) begin
      send_byte(8'($urandom));
      idle(10);
    end
    t0 = tmo_n;
    for (int i = 0; i < 5000 && tmo_n == t0; i++) idle(1);
    exp_err++;
    check_eq("t3_tmo_n", 129'(tmo_n - t0), 129'(1));
    check_eq("t3_tmo_dly", 129'(tmo_cyc - last_strobe), 129'(3828));
    check_eq("t3_errc", 129'(err_cnt), 129'(exp_cnt()));
    check_eq("t3_busy", 129'(busy), 129'(0));
    send_hdr(1'b0);
    send_payload(100);
    idle(2);
    check_block("t3_blk", 1'b0);

    // Parity error coinciding with the 9th byte.
    p0 = perr_n;
    v0 = valid_cyc;
    send_hdr(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom));
      idle(5);
    end
    rx_error = 1'b1;
    send_byte(8'h99);
    rx_error = 1'b0;
    idle(5);
    exp_err++;
    check_eq("t4_perr", 129'(perr_n - p0), 129'(1));
    check_eq("t4_novld", 129'(valid_cyc - v0), 129'(0));
    check_eq("t4_errc", 129'(err_cnt), 129'(exp_cnt()));
    send_hdr(1'b0);
    send_payload(40);
    idle(2);
    check_block("t4_blk", 1'b0);

    // Transfer in the same cycle as the next frame's first strobe.
    blk_ready = 1'b0;
    send_hdr(1'b0);
    send_payload(20);
    idle(3);
    check_eq("t5_valid", 129'(blk_valid), 129'(1));
    blk_ready = 1'b1;
    send_byte(Feat ? 8'h44 : 8'hAA);
    check_block("t5_old", 1'b0);
    frame_q = {8'hAA};
    if (Feat) send_byte(8'hAA);
    for (int i = 1; i < 16; i++) begin
      frame_q.push_back(8'($urandom));
      send_byte(frame_q[i]);
      idle(3);
    end
    idle(2);
    check_eq("t5_top", 129'(got_q.size() > 0 ? got_q[0][127:120] : 8'h00), 129'(8'hAA));
    check_block("t5_blk", 1'b0);

    // Randomized frames with occasional aborted partials.
    exp_q = {};
    got_q = {};
    for (int f = 0; f < 12; f++) begin
      logic key;
      key = 1'($urandom);
      if ($urandom_range(2, 0) == 0) begin
        send_hdr(key);
        for (int i = 0; i < int'($urandom_range(15, 1)); i++) begin
          send_byte(8'($urandom));
          idle($urandom_range(30, 0));
        end
        idle($urandom_range(50, 1));
        rx_error = 1'b1;
        idle(1);
        rx_error = 1'b0;
        idle(2);
        exp_err++;
      end
      send_hdr(key);
      send_payload(300);
      exp_q.push_back({key & Feat, pack(frame_q)});
      idle(2);
    end
    check_eq("rnd_cnt", 129'(got_q.size()), 129'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("rnd_blk%0d", i), got_q[i], exp_q[i]);
    end
    check_eq("rnd_errc", 129'(err_cnt), 129'(exp_cnt()));
    got_q = {};

`ifdef UART_ASM_KEYSEL_EN
    p0 = perr_n;
    send_byte(8'h55);
    idle(3);
    exp_err++;
    check_eq("hdr_bad", 129'(perr_n - p0), 129'(1));
    check_eq("hdr_bad_busy", 129'(busy), 129'(0));
    send_hdr(1'b1);
    send_payload(10);
    idle(2);
    check_block("hdr_key", 1'b1);
`endif

    // Asynchronous reset in the middle of a frame.
    send_hdr(1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    check_eq("pre_rst_busy", 129'(busy), 129'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_outs", 129'({blk_valid, blk_is_key, busy, timeout_pulse, perr_pulse,
                                overrun, err_cnt}), 129'(0));
    check_eq("arst_data", 129'(blk_data), 129'(0));
    idle(2);
    rst_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
